// File: rtl/usf_pkg.sv
// Shared definitions for the unlimited-sampling (USF) reconstruction blocks:
// default sample width, modulo threshold and the two-state sequencing enum.
package usf_pkg;

    localparam int USF_WIDTH  = 16;
    localparam int USF_LAMBDA = 10;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } usf_state_e;

endpackage

// File: rtl/mod_fold.sv
// Single-step modulo fold of a difference into [-LAMBDA, LAMBDA).
// The input is one bit wider than a sample so that sample differences never overflow.
module mod_fold
    import usf_pkg::*;
#(
    parameter int WIDTH  = USF_WIDTH,
    parameter int LAMBDA = USF_LAMBDA
) (
    input  logic signed [WIDTH:0] dy,
    output logic signed [WIDTH:0] folded
);

    localparam logic signed [WIDTH:0] LAM     = (WIDTH+1)'(LAMBDA);
    localparam logic signed [WIDTH:0] TWO_LAM = (WIDTH+1)'(2 * LAMBDA);

    // Differences of in-range samples are within one wrap, so one correction suffices.
    always_comb begin
        folded = dy;
        if (dy >= LAM) begin
            folded = dy - TWO_LAM;
        end else if (dy < -LAM) begin
            folded = dy + TWO_LAM;
        end
    end

endmodule

// File: rtl/modulo_residual_diff.sv
// Residual difference e[k] = M(dy) - dy of a modulo-folded sample stream, where
// dy is the first difference; three register levels give output two cycles after capture.
module modulo_residual_diff
    import usf_pkg::*;
#(
    parameter int WIDTH  = USF_WIDTH,
    parameter int LAMBDA = USF_LAMBDA
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] sample_in,
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] residual_diff_out,
    output logic                    range_err
);

    localparam logic signed [WIDTH-1:0] LAM_POS = WIDTH'(LAMBDA);
    localparam logic signed [WIDTH-1:0] LAM_NEG = -LAM_POS;

    // |e| <= 2*LAMBDA < 2^(WIDTH-1), so dropping the top bit is exact.
    function automatic logic signed [WIDTH-1:0] trunc_res(input logic signed [WIDTH:0] v);
        return $signed(v[WIDTH-1:0]);
    endfunction

    usf_state_e state_q, state_d;
    logic       issue_run;
    logic       sample_oor;

    logic signed [WIDTH-1:0] prev_sample;
    logic signed [WIDTH-1:0] smp_p0, prv_p0;
    logic                    vld_p0, oor_p0;
    logic signed [WIDTH:0]   dy_c;
    logic signed [WIDTH:0]   dy_p1;
    logic                    vld_p1, oor_p1;
    logic signed [WIDTH:0]   folded_p1;
    logic signed [WIDTH:0]   e_p1;
    logic signed [WIDTH-1:0] res_p2;
    logic                    vld_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == PRIME && valid_in) begin
            state_d = RUN;
        end
    end

    always_comb begin
        issue_run = valid_in && (state_q == RUN);
    end

    assign sample_oor = (sample_in >= LAM_POS) || (sample_in < LAM_NEG);

    // Stage p0: capture the sample and the previously accepted one.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_sample <= '0;
            smp_p0      <= '0;
            prv_p0      <= '0;
            vld_p0      <= 1'b0;
            oor_p0      <= 1'b0;
        end else begin
            vld_p0 <= issue_run;
            oor_p0 <= valid_in && sample_oor;
            if (valid_in) begin
                prev_sample <= sample_in;
                smp_p0      <= sample_in;
                prv_p0      <= prev_sample;
            end
        end
    end

    assign dy_c = $signed({smp_p0[WIDTH-1], smp_p0}) - $signed({prv_p0[WIDTH-1], prv_p0});

    // Stage p1: full-precision first difference.
    always_ff @(posedge clk) begin
        if (reset) begin
            dy_p1  <= '0;
            vld_p1 <= 1'b0;
            oor_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            oor_p1 <= oor_p0;
            if (vld_p0) begin
                dy_p1 <= dy_c;
            end
        end
    end

    mod_fold #(
        .WIDTH  (WIDTH),
        .LAMBDA (LAMBDA)
    ) u_fold (
        .dy     (dy_p1),
        .folded (folded_p1)
    );

    assign e_p1 = folded_p1 - dy_p1;

    // Stage p2: residual output register and sticky range flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_p2    <= '0;
            vld_p2    <= 1'b0;
            range_err <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (oor_p1) begin
                range_err <= 1'b1;
            end
            if (vld_p1) begin
                res_p2 <= trunc_res(e_p1);
            end
        end
    end

    assign valid_out         = vld_p2;
    assign residual_diff_out = res_p2;

endmodule
